// File: rtl/imm_extend_unit.sv
// Immediate-extension stage: zero/sign/upper extension plus a prefix register for
// building full-width constants, feeding a 2-entry in-order output buffer.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             pfx_active
);

  localparam int PFX_W = OUT_W - IN_W;

  generate
    if (OUT_W <= IN_W || OUT_W > 2 * IN_W) begin : g_param_check
      $error("imm_extend_unit: OUT_W must satisfy IN_W < OUT_W <= 2*IN_W");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_PFX} state_t;

  state_t             state_q, state_d;
  logic [PFX_W-1:0]   pfx_q, pfx_d;
  logic [OUT_W-1:0]   mem_q [2];
  logic [OUT_W-1:0]   ext_val;
  logic               rd_q, wr_q;
  logic [1:0]         count_q, count_d;
  logic               accept, is_pfx, push, pop;

  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign imm_out    = mem_q[rd_q];
  assign pfx_active = (state_q == S_PFX);

  assign accept = in_valid & in_ready;
  assign is_pfx = (mode == 2'b11);
  assign pop    = out_valid & out_ready & ~flush;

  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    push    = 1'b0;
    ext_val = {{PFX_W{1'b0}}, imm_in};
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_pfx) begin
            state_d = S_PFX;
            pfx_d   = imm_in[PFX_W-1:0];
          end else begin
            push = 1'b1;
            case (mode)
              2'b01:   ext_val = {{PFX_W{imm_in[IN_W-1]}}, imm_in};
              2'b10:   ext_val = {imm_in[PFX_W-1:0], {IN_W{1'b0}}};
              default: ext_val = {{PFX_W{1'b0}}, imm_in};
            endcase
          end
        end
      end
      S_PFX: begin
        if (accept) begin
          if (is_pfx) begin
            pfx_d = imm_in[PFX_W-1:0];
          end else begin
            // Mode is ignored here: the pending prefix supplies the high bits.
            push    = 1'b1;
            ext_val = {pfx_q, imm_in};
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush discards the whole cycle's transfer, including a prefix overwrite.
    if (flush) begin
      state_d = S_IDLE;
      pfx_d   = pfx_q;
      push    = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pfx_q    <= '0;
      count_q  <= 2'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      pfx_q   <= pfx_d;
      count_q <= count_d;
      if (flush) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_q] <= ext_val;
          wr_q        <= ~wr_q;
        end
        if (pop) begin
          rd_q <= ~rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit (IN_W=8, OUT_W=16): tasks queue expected
// outputs as they drive, a negedge monitor pops and compares each delivered word.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  imm_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] imm_out;
  logic        pfx_active;

  int vectors    = 0;
  int miscompares = 0;
  logic [15:0] sb [$];

  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_in     (imm_in),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .imm_out    (imm_out),
    .pfx_active (pfx_active)
  );

  always #5 clk = ~clk;

  // A handshake seen at the negedge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got imm_out=%h, expected no output", imm_out);
      end else begin
        if (imm_out !== sb[0]) begin
          miscompares++;
          $display("FAIL sb_data: got imm_out=%h, expected %h", imm_out, sb[0]);
        end else begin
          $display("pop imm_out=%h ok", imm_out);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic [1:0] m);
    in_valid = 1'b1;
    imm_in   = v;
    mode     = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d entries outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (pfx_active !== 1'b0) begin miscompares++; $display("FAIL reset_pfx_active: got %b expected 0", pfx_active); end
    if (imm_out !== 16'h0000) begin miscompares++; $display("FAIL reset_imm_out: got %h expected 0000", imm_out); end
    $display("reset checked");
  endtask

  task automatic test_modes();
    logic [15:0] exp_tab [3];
    exp_tab[0] = 16'h0085;
    exp_tab[1] = 16'hFF85;
    exp_tab[2] = 16'h8500;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exp_tab[i]);
      in_valid = 1'b1;
      imm_in   = 8'h85;
      mode     = 2'(i);
      step();
      vectors++;
      if (out_valid !== 1'b1 || imm_out !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL mode%0d_latency: got valid=%b imm_out=%h expected valid=1 %h", i, out_valid, imm_out, exp_tab[i]);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL modes_idle: got out_valid=%b expected 0", out_valid); end
    drain("modes");
  endtask

  task automatic test_prefix();
    out_ready = 1'b1;
    send(8'hAB, 2'b11);
    vectors++;
    if (pfx_active !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pfx_load: got pfx_active=%b out_valid=%b expected 1 0", pfx_active, out_valid);
    end
    sb.push_back(16'hABCD);
    send(8'hCD, 2'b01);
    vectors++;
    if (pfx_active !== 1'b0 || out_valid !== 1'b1 || imm_out !== 16'hABCD) begin
      miscompares++;
      $display("FAIL pfx_use: got pfx=%b valid=%b imm_out=%h expected 0 1 abcd", pfx_active, out_valid, imm_out);
    end
    send(8'h12, 2'b11);
    send(8'h34, 2'b11);
    vectors++;
    if (pfx_active !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pfx_overwrite: got pfx_active=%b out_valid=%b expected 1 0", pfx_active, out_valid);
    end
    sb.push_back(16'h3456);
    send(8'h56, 2'b00);
    vectors++;
    if (imm_out !== 16'h3456 || pfx_active !== 1'b0) begin
      miscompares++;
      $display("FAIL pfx_rebuild: got imm_out=%h pfx=%b expected 3456 0", imm_out, pfx_active);
    end
    drain("prefix");
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    sb.push_back(16'h0001);
    sb.push_back(16'h0002);
    sb.push_back(16'h0003);
    send(8'h01, 2'b00);
    send(8'h02, 2'b00);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got in_ready=%b expected 0", in_ready); end
    in_valid = 1'b1;
    imm_in   = 8'h03;
    mode     = 2'b00;
    step();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || imm_out !== 16'h0001) begin
      miscompares++;
      $display("FAIL bp_stall: got in_ready=%b valid=%b imm_out=%h expected 0 1 0001", in_ready, out_valid, imm_out);
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (n >= 10) begin miscompares++; $display("FAIL bp_timeout: got in_ready=0 after %0d cycles expected 1", n); end
    drain("backpressure");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(8'h11, 2'b00);
    send(8'h22, 2'b11);
    flush    = 1'b1;
    in_valid = 1'b1;
    imm_in   = 8'h77;
    mode     = 2'b00;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || pfx_active !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state: got valid=%b pfx=%b ready=%b expected 0 0 1", out_valid, pfx_active, in_ready);
    end
    out_ready = 1'b1;
    sb.push_back(16'hFF80);
    send(8'h80, 2'b01);
    vectors++;
    if (out_valid !== 1'b1 || imm_out !== 16'hFF80) begin
      miscompares++;
      $display("FAIL flush_after: got valid=%b imm_out=%h expected 1 ff80", out_valid, imm_out);
    end
    drain("flush");
  endtask

  task automatic check_async(input string name);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pfx_active !== 1'b0 || imm_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: got valid=%b ready=%b pfx=%b imm_out=%h expected 0 1 0 0000",
               name, out_valid, in_ready, pfx_active, imm_out);
    end else begin
      $display("%s outputs at reset values", name);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(8'h01, 2'b00);
    send(8'hAA, 2'b11);
    vectors++;
    if (pfx_active !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_setup: got pfx=%b valid=%b expected 1 1", pfx_active, out_valid);
    end
    check_async("arst_prefix");
    send(8'h01, 2'b00);
    send(8'h02, 2'b00);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_full: got in_ready=%b expected 0", in_ready); end
    check_async("arst_full");
    out_ready = 1'b1;
    sb.push_back(16'h0042);
    send(8'h42, 2'b00);
    drain("arst_resume");
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    imm_in    = 8'h00;
    mode      = 2'b00;
    out_ready = 1'b1;
    #22;
    rst_n = 1'b1;
    step();
    test_reset();
    test_modes();
    test_prefix();
    test_back_to_back();
    test_flush();
    test_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
